pack_phase_sequencer: RTL and testbench

//  Sequencer for the 10b->20b video packing datapath. Aligns the pack phase to hsync falling edge, marks completed
//  20-bit words and counts samples and lines. Checks each line length against a programmed value and reports

---
 rtl/pack_phase_sequencer_if.sv | 41 ++++
 rtl/pack_phase_sequencer.sv | 121 ++++++++++++
 tb/tb_pack_phase_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pack_phase_sequencer_if.sv
// Video-side bundle for the 10b->20b pack phase sequencer.
// err_count exists only when PACK_SEQ_ERRCNT_EN is defined.
interface pack_phase_sequencer_if #(
    parameter int CNT_W  = 12,
    parameter int LINE_W = 11
);
    logic              hsync;
    logic              vsync;
    logic              fsync;
    logic [CNT_W-1:0]  expected_len;
    logic              phase;
    logic              word_valid;
    logic              hsync_out;
    logic              vsync_out;
    logic              fsync_out;
    logic [CNT_W-1:0]  sample_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic              locked;
    logic              len_err;
`ifdef PACK_SEQ_ERRCNT_EN
    logic [15:0]       err_count;
`endif

    modport master (
`ifdef PACK_SEQ_ERRCNT_EN
        input  err_count,
`endif
        output hsync, vsync, fsync, expected_len,
        input  phase, word_valid, hsync_out, vsync_out, fsync_out,
        input  sample_cnt, line_cnt, locked, len_err
    );

    modport slave (
`ifdef PACK_SEQ_ERRCNT_EN
        output err_count,
`endif
        input  hsync, vsync, fsync, expected_len,
        output phase, word_valid, hsync_out, vsync_out, fsync_out,
        output sample_cnt, line_cnt, locked, len_err
    );
endinterface

// File: rtl/pack_phase_sequencer.sv
// Pack phase sequencer: aligns 20-bit word pairing to hsync fall, counts samples/lines, checks line length.
// Optional PACK_SEQ_ERRCNT_EN adds a saturating bad-line counter cleared on vsync rise.
module pack_phase_sequencer #(
    parameter int CNT_W      = 12,
    parameter int LINE_W     = 11,
    parameter int LOCK_LINES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pack_phase_sequencer_if.slave bus
);
    localparam int                GOOD_W   = $clog2(LOCK_LINES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [LINE_W-1:0] LINE_MAX = '1;
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_LINES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic              hs_d;
    logic              vs_d;
    logic              ovf;
    logic [GOOD_W-1:0] good_cnt;

    logic              hs_fall;
    logic              vs_rise;
    logic [CNT_W:0]    line_len;
    logic              len_mismatch;
    logic              line_bad;
    logic              bad_event;
    logic [CNT_W-1:0]  next_idx;
    logic [GOOD_W-1:0] next_good;

    assign hs_fall = hs_d & ~bus.hsync;
    assign vs_rise = ~vs_d & bus.vsync;

    // The sample that just ended the line is the registered index, so length is that index plus one.
    assign line_len     = {1'b0, bus.sample_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign len_mismatch = (bus.expected_len != '0) && (line_len != {1'b0, bus.expected_len});
    assign line_bad     = line_len[0] | ovf | len_mismatch;
    assign bad_event    = (state == RUN) & hs_fall & line_bad;

    assign next_idx  = hs_fall ? '0 :
                       (bus.sample_cnt == CNT_MAX) ? CNT_MAX : bus.sample_cnt + 1'b1;
    assign next_good = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            hs_d           <= 1'b0;
            vs_d           <= 1'b0;
            ovf            <= 1'b0;
            good_cnt       <= '0;
            bus.phase      <= 1'b0;
            bus.word_valid <= 1'b0;
            bus.hsync_out  <= 1'b0;
            bus.vsync_out  <= 1'b0;
            bus.fsync_out  <= 1'b0;
            bus.sample_cnt <= '0;
            bus.line_cnt   <= '0;
            bus.locked     <= 1'b0;
            bus.len_err    <= 1'b0;
        end else begin
            hs_d          <= bus.hsync;
            vs_d          <= bus.vsync;
            bus.hsync_out <= bus.hsync;
            bus.vsync_out <= bus.vsync;
            bus.fsync_out <= bus.fsync;
            bus.len_err   <= 1'b0;

            if (vs_rise)
                bus.line_cnt <= '0;
            else if ((state == RUN) && hs_fall && (bus.line_cnt != LINE_MAX))
                bus.line_cnt <= bus.line_cnt + 1'b1;

            case (state)
                IDLE: begin
                    bus.phase      <= 1'b0;
                    bus.word_valid <= 1'b0;
                    bus.sample_cnt <= '0;
                    if (hs_fall) begin
                        state <= RUN;
                        ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    // Phase free-runs from the line start so pairing survives index saturation.
                    bus.sample_cnt <= next_idx;
                    bus.phase      <= hs_fall ? 1'b0 : ~bus.phase;
                    bus.word_valid <= hs_fall ? 1'b0 : ~bus.phase;
                    if (hs_fall) begin
                        ovf <= 1'b0;
                        if (line_bad) begin
                            bus.len_err <= 1'b1;
                            good_cnt    <= '0;
                            bus.locked  <= 1'b0;
                        end else begin
                            good_cnt   <= next_good;
                            bus.locked <= (bus.expected_len != '0) && (next_good == GOOD_MAX);
                        end
                    end else if (next_idx == CNT_MAX) begin
                        ovf <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PACK_SEQ_ERRCNT_EN
    // A vsync rise restarts the count but still records a bad line ending on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.err_count <= '0;
        else if (vs_rise)
            bus.err_count <= bad_event ? 16'd1 : 16'd0;
        else if (bad_event && (bus.err_count != 16'hFFFF))
            bus.err_count <= bus.err_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pack_phase_sequencer.sv
// Directed bench for pack_phase_sequencer: lock acquisition, bad lines, line counting, mid-line reset.
// err_count checks are compiled in only with PACK_SEQ_ERRCNT_EN.
module tb_pack_phase_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pack_phase_sequencer_if #(.CNT_W(12), .LINE_W(11)) bus ();

    pack_phase_sequencer #(.CNT_W(12), .LINE_W(11), .LOCK_LINES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line of len samples; line-end results of the previous line are checked on its first sample.
    task automatic applyStimulus(input int len, input logic exp_err, input logic exp_lock,
                                 input int exp_lc, input logic vs_start, input logic [11:0] next_exp);
        for (int i = 0; i < len; i++) begin
            bus.hsync = (i == len - 1);
            bus.vsync = (i == 0) ? vs_start : 1'b0;
            bus.fsync = (i == 1);
            tick();
            checkOutput("sample_cnt", 32'(bus.sample_cnt), 32'(i));
            checkOutput("phase", 32'(bus.phase), 32'(i % 2));
            checkOutput("word_valid", 32'(bus.word_valid), 32'(i % 2));
            checkOutput("hsync_out", 32'(bus.hsync_out), 32'(bus.hsync));
            checkOutput("vsync_out", 32'(bus.vsync_out), 32'(bus.vsync));
            checkOutput("fsync_out", 32'(bus.fsync_out), 32'(bus.fsync));
            if (i == 0) begin
                checkOutput("len_err_at_end", 32'(bus.len_err), 32'(exp_err));
                checkOutput("locked_at_end", 32'(bus.locked), 32'(exp_lock));
                if (exp_lc >= 0)
                    checkOutput("line_cnt", 32'(bus.line_cnt), 32'(exp_lc));
                bus.expected_len = next_exp;
            end else begin
                checkOutput("len_err_pulse", 32'(bus.len_err), 32'd0);
            end
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        bus.hsync        = 1'b0;
        bus.vsync        = 1'b0;
        bus.fsync        = 1'b0;
        bus.expected_len = 12'd8;
        tick();
        tick();
        checkOutput("rst_sample_cnt", 32'(bus.sample_cnt), 32'd0);
        checkOutput("rst_locked", 32'(bus.locked), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset with no hsync activity.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("idle_phase", 32'(bus.phase), 32'd0);
            checkOutput("idle_word_valid", 32'(bus.word_valid), 32'd0);
            checkOutput("idle_sample_cnt", 32'(bus.sample_cnt), 32'd0);
            checkOutput("idle_line_cnt", 32'(bus.line_cnt), 32'd0);
            checkOutput("idle_len_err", 32'(bus.len_err), 32'd0);
            checkOutput("idle_hsync_out", 32'(bus.hsync_out), 32'd0);
        end
        bus.hsync = 1'b1;
        tick();
        checkOutput("idle_hs_high_phase", 32'(bus.phase), 32'd0);
        checkOutput("idle_hs_high_hsync_out", 32'(bus.hsync_out), 32'd1);

        // Lock acquisition at 8 samples per line.
        applyStimulus(8, 1'b0, 1'b0, -1, 1'b0, 12'd8);
        applyStimulus(8, 1'b0, 1'b0, -1, 1'b0, 12'd8);
        applyStimulus(8, 1'b0, 1'b0, -1, 1'b0, 12'd8);
        applyStimulus(8, 1'b0, 1'b0, -1, 1'b0, 12'd8);
        applyStimulus(8, 1'b0, 1'b1, -1, 1'b0, 12'd8);
        applyStimulus(8, 1'b0, 1'b1, -1, 1'b0, 12'd8);

        // A 9-sample line breaks lock; four good lines restore it.
        applyStimulus(9, 1'b0, 1'b1, -1, 1'b0, 12'd8);
        applyStimulus(8, 1'b1, 1'b0, -1, 1'b0, 12'd8);
        applyStimulus(8, 1'b0, 1'b0, -1, 1'b0, 12'd8);
        applyStimulus(8, 1'b0, 1'b0, -1, 1'b0, 12'd8);
        applyStimulus(8, 1'b0, 1'b0, -1, 1'b0, 12'd8);

        // Length check off: 10 is fine, 7 is odd.
        applyStimulus(10, 1'b0, 1'b1, -1, 1'b0, 12'd0);
        applyStimulus(7, 1'b0, 1'b0, -1, 1'b0, 12'd0);
        applyStimulus(3, 1'b1, 1'b0, -1, 1'b0, 12'd0);

        // vsync rise alone extends the 3-sample line to 4 and clears line_cnt.
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        tick();
        checkOutput("vs_only_line_cnt", 32'(bus.line_cnt), 32'd0);
        checkOutput("vs_only_sample_cnt", 32'(bus.sample_cnt), 32'd3);
        bus.vsync = 1'b0;

        for (int k = 1; k <= 37; k++)
            applyStimulus(2, 1'b0, 1'b0, k, 1'b0, 12'd0);
        applyStimulus(2, 1'b0, 1'b0, 0, 1'b1, 12'd0);
        applyStimulus(2, 1'b0, 1'b0, 1, 1'b0, 12'd0);
        applyStimulus(2, 1'b0, 1'b0, 2, 1'b0, 12'd0);

        // Mid-line asynchronous reset.
        bus.hsync = 1'b0;
        tick();
        checkOutput("pre_rst_line_cnt", 32'(bus.line_cnt), 32'd3);
        tick();
        checkOutput("pre_rst_word_valid", 32'(bus.word_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_line_cnt", 32'(bus.line_cnt), 32'd0);
        checkOutput("async_rst_sample_cnt", 32'(bus.sample_cnt), 32'd0);
        checkOutput("async_rst_word_valid", 32'(bus.word_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        checkOutput("post_rst_idle_cnt", 32'(bus.sample_cnt), 32'd0);
        bus.hsync = 1'b1;
        tick();

        // Re-entry is unchecked; then three odd lines and a vsync-coincident fourth.
        applyStimulus(3, 1'b0, 1'b0, -1, 1'b0, 12'd0);
        applyStimulus(3, 1'b1, 1'b0, -1, 1'b0, 12'd0);
        applyStimulus(3, 1'b1, 1'b0, -1, 1'b0, 12'd0);
        applyStimulus(3, 1'b1, 1'b0, -1, 1'b0, 12'd0);
`ifdef PACK_SEQ_ERRCNT_EN
        checkOutput("err_count_3", 32'(bus.err_count), 32'd3);
`endif
        applyStimulus(2, 1'b1, 1'b0, 0, 1'b1, 12'd0);
`ifdef PACK_SEQ_ERRCNT_EN
        checkOutput("err_count_vs_clear", 32'(bus.err_count), 32'd1);
`endif
        applyStimulus(2, 1'b0, 1'b0, 1, 1'b0, 12'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
